// File: rtl/spi_s2p_param.sv
// Parametrised SPI serial-to-parallel receiver: WIDTH-bit words, MSB- or LSB-first.
// Define SPI_S2P_PARITY_EN to append and check one even-parity bit per frame.
module spi_s2p_param #(
  parameter int WIDTH     = 10,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             MOSI,
  input  logic             En_S2P,
  input  logic             frame_clr,
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_valid,
  output logic             busy,
  output logic             parity_err
);

  localparam int CNT_W = $clog2(WIDTH + 1);
`ifdef SPI_S2P_PARITY_EN
  localparam int FRAME_LEN = WIDTH + 1;
`else
  localparam int FRAME_LEN = WIDTH;
`endif
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(FRAME_LEN - 1);

  logic [WIDTH-1:0] sreg;
  logic [WIDTH-1:0] shifted;
  logic [CNT_W-1:0] cnt;

  // Shift direction decides which end of the word the first bit reaches.
  always_comb begin
    shifted = MSB_FIRST ? {sreg[WIDTH-2:0], MOSI} : {MOSI, sreg[WIDTH-1:1]};
  end

  // NOTE: all state uses non-blocking assignments so every register samples
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sreg     <= '0;
      cnt      <= '0;
      rx_data  <= '0;
      rx_valid <= 1'b0;
      busy     <= 1'b0;
`ifdef SPI_S2P_PARITY_EN
      parity_err <= 1'b0;
`endif
    end else begin
      rx_valid <= 1'b0;
`ifdef SPI_S2P_PARITY_EN
      parity_err <= 1'b0;
`endif
      if (frame_clr) begin
        sreg <= '0;
        cnt  <= '0;
        busy <= 1'b0;
      end else if (En_S2P) begin
        if (cnt == LAST_BIT) begin
          cnt      <= '0;
          busy     <= 1'b0;
          rx_valid <= 1'b1;
`ifdef SPI_S2P_PARITY_EN
          // Current MOSI is the parity bit; the data word is already complete.
          rx_data    <= sreg;
          parity_err <= ^{sreg, MOSI};
`else
          rx_data <= shifted;
`endif
        end else begin
          sreg <= shifted;
          cnt  <= cnt + CNT_W'(1);
          busy <= 1'b1;
        end
      end
    end
  end

`ifndef SPI_S2P_PARITY_EN
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_spi_s2p_param.sv
// Directed self-checking bench for spi_s2p_param: a 10-bit MSB-first and an
// 8-bit LSB-first instance, frame abort, async reset, gaps and optional parity.
module tb_spi_s2p_param;

  logic       clk = 1'b0;
  logic       rst;

  logic       mosi_a, en_a, clr_a;
  logic [9:0] data_a;
  logic       valid_a, busy_a, perr_a;

  logic       mosi_b, en_b, clr_b;
  logic [7:0] data_b;
  logic       valid_b, busy_b, perr_b;

  int checks   = 0;
  int failures = 0;

`ifdef SPI_S2P_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif

  always #5 clk = ~clk;

  spi_s2p_param #(.WIDTH(10), .MSB_FIRST(1'b1)) u_a (
    .clk(clk), .rst(rst), .MOSI(mosi_a), .En_S2P(en_a), .frame_clr(clr_a),
    .rx_data(data_a), .rx_valid(valid_a), .busy(busy_a), .parity_err(perr_a)
  );

  spi_s2p_param #(.WIDTH(8), .MSB_FIRST(1'b0)) u_b (
    .clk(clk), .rst(rst), .MOSI(mosi_b), .En_S2P(en_b), .frame_clr(clr_b),
    .rx_data(data_b), .rx_valid(valid_b), .busy(busy_b), .parity_err(perr_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One enabled bit on instance A; returns 1 ns after the sampling edge.
  task automatic bit_a(input logic m);
    mosi_a = m;
    en_a   = 1'b1;
    @(posedge clk);
    #1;
    en_a   = 1'b0;
  endtask

  task automatic bit_b(input logic m);
    mosi_b = m;
    en_b   = 1'b1;
    @(posedge clk);
    #1;
    en_b   = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Full MSB-first frame on A, plus even-parity bit when compiled in.
  task automatic frame_a(input logic [9:0] w);
    for (int i = 9; i >= 0; i--) bit_a(w[i]);
    if (PAR == 1) bit_a(^w);
  endtask

  task automatic frame_b(input logic [7:0] w);
    for (int i = 0; i < 8; i++) bit_b(w[i]);
    if (PAR == 1) bit_b(^w);
  endtask

  initial begin
    logic [9:0] w10;
    logic [15:0] stream;
    int pulses;
    int first_idx, second_idx;
    logic [7:0] first_data, second_data;

    rst = 1'b0;
    mosi_a = 1'b0; en_a = 1'b0; clr_a = 1'b0;
    mosi_b = 1'b0; en_b = 1'b0; clr_b = 1'b0;

    // Reset pulse and reset state
    #2 rst = 1'b1;
    #1;
    check("rst_data_a",  32'(data_a),  32'h0);
    check("rst_valid_a", 32'(valid_a), 32'h0);
    check("rst_busy_a",  32'(busy_a),  32'h0);
    check("rst_perr_a",  32'(perr_a),  32'h0);
    check("rst_data_b",  32'(data_b),  32'h0);
    idle(2);
    rst = 1'b0;
    idle(1);

    // Test 1: bits 1,0,1,1,0,0,1,0,1,1 MSB-first -> 0x2CB
    w10 = 10'h2CB;
    for (int i = 9; i >= 1; i--) bit_a(w10[i]);
    check("t1_busy_mid", 32'(busy_a), 32'h1);
    check("t1_valid_early", 32'(valid_a), 32'h0);
    bit_a(w10[0]);
    if (PAR == 1) bit_a(^w10);
    check("t1_valid", 32'(valid_a), 32'h1);
    check("t1_data",  32'(data_a),  32'h2CB);
    check("t1_busy",  32'(busy_a),  32'h0);
    check("t1_perr",  32'(perr_a),  32'h0);
    idle(1);
    check("t1_valid_drop", 32'(valid_a), 32'h0);
    check("t1_data_hold",  32'(data_a),  32'h2CB);

    // Test 2: LSB-first 8-bit, 0x01 then 0x01,0xA5 back-to-back
    frame_b(8'h01);
    check("t2_valid", 32'(valid_b), 32'h1);
    check("t2_data",  32'(data_b),  32'h01);
    idle(1);
    stream = 16'hA501;
    pulses = 0; first_idx = -1; second_idx = -1;
    first_data = '0; second_data = '0;
    for (int i = 0; i < 16 + 2 * PAR; i++) begin
      if (PAR == 1 && i == 8)       bit_b(^stream[7:0]);
      else if (PAR == 1 && i == 17) bit_b(^stream[15:8]);
      else if (PAR == 1 && i > 8)   bit_b(stream[i-1]);
      else                          bit_b(stream[i]);
      if (valid_b) begin
        pulses++;
        if (pulses == 1) begin first_idx = i; first_data = data_b; end
        else begin second_idx = i; second_data = data_b; end
      end
    end
    check("t2_pulses",   32'(pulses), 32'd2);
    check("t2_spacing",  32'(second_idx - first_idx), 32'(8 + PAR));
    check("t2_data0",    32'(first_data),  32'h01);
    check("t2_data1",    32'(second_data), 32'hA5);
    check("t2_busy_end", 32'(busy_b), 32'h0);

    // Test 3: 4 bits, 5 idle cycles, remaining 6 bits -> 0x1B4
    w10 = 10'h1B4;
    for (int i = 9; i >= 6; i--) bit_a(w10[i]);
    for (int g = 0; g < 5; g++) begin
      mosi_a = g[0];
      idle(1);
      check("t3_busy_gap", 32'(busy_a), 32'h1);
      check("t3_no_valid", 32'(valid_a), 32'h0);
    end
    for (int i = 5; i >= 0; i--) bit_a(w10[i]);
    if (PAR == 1) bit_a(^w10);
    check("t3_valid", 32'(valid_a), 32'h1);
    check("t3_data",  32'(data_a),  32'h1B4);

    // Test 4: abort after 6 bits with En_S2P high in the same cycle
    for (int i = 0; i < 6; i++) bit_a(1'b1);
    mosi_a = 1'b1; en_a = 1'b1; clr_a = 1'b1;
    @(posedge clk);
    #1;
    en_a = 1'b0; clr_a = 1'b0;
    check("t4_clr_valid", 32'(valid_a), 32'h0);
    check("t4_clr_busy",  32'(busy_a),  32'h0);
    check("t4_clr_data",  32'(data_a),  32'h1B4);
    frame_a(10'h155);
    check("t4_fresh_valid", 32'(valid_a), 32'h1);
    check("t4_fresh_data",  32'(data_a),  32'h155);
    for (int i = 0; i < 6; i++) bit_a(1'b1);
    #2 rst = 1'b1;
    #1;
    check("t4_rst_data",  32'(data_a),  32'h0);
    check("t4_rst_busy",  32'(busy_a),  32'h0);
    check("t4_rst_valid", 32'(valid_a), 32'h0);
    idle(1);
    rst = 1'b0;
    idle(1);
    frame_a(10'h2CB);
    check("t4_after_rst", 32'(data_a), 32'h2CB);

`ifdef SPI_S2P_PARITY_EN
    // Test 5: 0x03 with correct and wrong parity bit
    for (int i = 0; i < 8; i++) bit_b(i < 2);
    bit_b(1'b0);
    check("t5_ok_valid", 32'(valid_b), 32'h1);
    check("t5_ok_perr",  32'(perr_b),  32'h0);
    check("t5_ok_data",  32'(data_b),  32'h03);
    for (int i = 0; i < 8; i++) bit_b(i < 2);
    bit_b(1'b1);
    check("t5_bad_valid", 32'(valid_b), 32'h1);
    check("t5_bad_perr",  32'(perr_b),  32'h1);
    check("t5_bad_data",  32'(data_b),  32'h03);
    idle(1);
    check("t5_perr_drop", 32'(perr_b), 32'h0);
`else
    frame_b(8'h03);
    check("t5_data",    32'(data_b), 32'h03);
    check("t5_perr_tie", 32'(perr_b), 32'h0);
`endif

    // Test 6: 50 disabled cycles with MOSI toggling
    pulses = 0;
    for (int i = 0; i < 50; i++) begin
      mosi_a = i[0];
      idle(1);
      if (valid_a || busy_a) pulses++;
    end
    check("t6_quiet", 32'(pulses), 32'd0);
    frame_a(10'h3C1);
    check("t6_after_valid", 32'(valid_a), 32'h1);
    check("t6_after_data",  32'(data_a),  32'h3C1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
